// File: rtl/mant_mult_seq.sv
// Sequential shift-and-add mantissa multiplier with valid/ready handshakes.
// One N-bit carry-lookahead addition per iteration; N iterations per product.

// N-bit carry-lookahead adder: every carry is formed directly from the
// generate/propagate terms rather than rippling through the previous stage.
module mant_cla #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] gen_s;
  logic [N-1:0] prop_s;
  logic [N:0]   carry_s;

  // Generate/propagate terms and the flattened lookahead carry equations.
  always_comb begin
    logic term_v;
    logic pprod_v;
    gen_s      = x & y;
    prop_s     = x ^ y;
    carry_s    = '0;
    carry_s[0] = cin;
    term_v     = 1'b0;
    pprod_v    = 1'b0;
    for (int i = 0; i < N; i++) begin
      term_v  = gen_s[i];
      pprod_v = prop_s[i];
      for (int j = i - 1; j >= 0; j--) begin
        term_v  = term_v | (pprod_v & gen_s[j]);
        pprod_v = pprod_v & prop_s[j];
      end
      carry_s[i+1] = term_v | (pprod_v & cin);
    end
  end

  // Sum bits and the carry out of the top position.
  always_comb begin
    sum  = prop_s ^ carry_s[N-1:0];
    cout = carry_s[N];
  end

endmodule

module mant_mult_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  m_q, m_d;
  logic [N-1:0]  p_q, p_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  sum_s;
  logic          cout_s;

  // Accumulator plus multiplicand; carry-in is always zero.
  mant_cla #(.N(N)) u_cla (
    .x    (p_q),
    .y    (m_q),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // State register; reset always lands in IDLE, even mid-run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept, count N iterations, then wait for handoff.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register; in_ready is masked by rst.
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    out_valid = (state_q == S_DONE);
    product   = {p_q, q_q};
  end

  // Datapath next state: load operands, or one add-and-shift step per cycle.
  // The adder carry becomes the new top bit of P so large operands stay exact.
  always_comb begin
    m_d   = m_q;
    p_d   = p_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          m_d   = a;
          q_d   = b;
          p_d   = '0;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        if (q_q[0]) begin
          p_d = {cout_s, sum_s[N-1:1]};
          q_d = {sum_s[0], q_q[N-1:1]};
        end else begin
          p_d = {1'b0, p_q[N-1:1]};
          q_d = {p_q[0], q_q[N-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
      end
      S_DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath registers; reset clears the partial result so product reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q   <= '0;
      p_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      p_q   <= p_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
